fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the asynchronous instruction ROM. Holds the program counter, drives the ROM address, captures the same-cycle ROM data into a small prefetch FIFO, and presents {pc, instruction} to decode over a valid/ready handshake. Supports control-flow redirect with flush, and faults on an unbacked fetch address.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch controller state (RUN, FAULT).
//   fetch_entry_t : prefetch FIFO entry {pc, data}. It is sized to the widest
//                   PC/instruction supported, and narrower instances zero-extend
//                   into it.
//   last_addr()   : the single unbacked ROM word address for a given address width.
package fetch_pkg;

  localparam int MAX_ADDR_W = 16;
  localparam int MAX_DATA_W = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] pc;
    logic [MAX_DATA_W-1:0] data;
  } fetch_entry_t;

  // Returns the all-ones word address for the given width. The ROM does not
  // back that address.
  function automatic logic [MAX_ADDR_W-1:0] last_addr(input int w);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with registered storage.
//   clk, rst   : clock and synchronous active-high reset (empties the FIFO).
//   flush      : synchronous clear. It overrides push and pop in the same cycle.
//   push/wr_data : write request. It is accepted when the FIFO is not full, or
//                  when it is full and a pop happens in the same cycle.
//   pop/rd_data  : rd_data is the head entry. A pop removes the head when the
//                  FIFO is not empty.
//   full, empty  : occupancy flags.
// DEPTH must be a power of two so that the pointers wrap naturally.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t wr_data,
  input  logic   pop,
  output entry_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately left unreset. The pointers and count define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of an asynchronous ROM.
//   clk, rst       : clock and synchronous active-high reset.
//   rom_addr       : ROM word address, driven straight from the PC register.
//   rom_data       : same-cycle ROM read data for rom_addr.
//   instr_valid/instr_ready : decode handshake on the prefetch FIFO head.
//   instr_data, instr_pc    : head instruction and its PC. Both are zero when
//                             nothing is presented.
//   redirect_valid, redirect_pc : control-flow change. It flushes the FIFO and
//                                 reloads the PC.
//   fault          : fetch halted because the PC points at the unbacked address.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fault
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(last_addr(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

  if (PC_INIT == LAST) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must not be the unbacked address");
  end
  if (ADDR_WIDTH > MAX_ADDR_W || DATA_WIDTH > MAX_DATA_W) begin : g_bad_width
    $error("fetch_unit: width exceeds fetch_pkg entry size");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: FIFO_DEPTH must be a power of two >= 2");
  end

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  push, pop, full, empty;
  fetch_entry_t          wr_entry, head;
  logic                  unused_head_bits;

  assign rom_addr    = pc_q;
  assign fault       = (state_q == FAULT);
  assign instr_valid = !empty && (state_q == RUN);
  assign pop         = instr_valid && instr_ready;
  assign instr_pc    = instr_valid ? head.pc[ADDR_WIDTH-1:0]   : '0;
  assign instr_data  = instr_valid ? head.data[DATA_WIDTH-1:0] : '0;
  assign wr_entry    = '{pc: MAX_ADDR_W'(pc_q), data: MAX_DATA_W'(rom_data)};
  // Narrow instances ignore the upper bits of the shared entry.
  assign unused_head_bits = ^head;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = (redirect_pc == LAST) ? FAULT : RUN;
    end else if (state_q == RUN && (!full || pop)) begin
      push = 1'b1;
      // Skip the unbacked address: LAST-1 wraps back to 0.
      pc_d = (pc_q == LAST - 1'b1) ? '0 : pc_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sync_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Two instances share the clock
// and reset: u8 uses the default 8-bit PC, and u4 uses a 4-bit PC that starts
// at 13 to cover the wrap past the unbacked address. Each ROM word is
// base | address.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  rom_addr8, pc8, rpc8;
  logic [31:0] rom_data8, data8;
  logic        valid8, ready8, rv8, fault8;

  logic [3:0]  rom_addr4, pc4, rpc4;
  logic [31:0] rom_data4, data4;
  logic        valid4, ready4, rv4, fault4;

  int total = 0;
  int bad   = 0;

  assign rom_data8 = 32'hA000_0000 | {24'h0, rom_addr8};
  assign rom_data4 = 32'hB000_0000 | {28'h0, rom_addr4};

  always #5 clk = ~clk;

  fetch_unit u8 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr8), .rom_data(rom_data8),
    .instr_valid(valid8), .instr_ready(ready8), .instr_data(data8),
    .instr_pc(pc8), .redirect_valid(rv8), .redirect_pc(rpc8), .fault(fault8)
  );

  fetch_unit #(.ADDR_WIDTH(4), .RESET_PC(13)) u4 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr4), .rom_data(rom_data4),
    .instr_valid(valid4), .instr_ready(ready4), .instr_data(data4),
    .instr_pc(pc4), .redirect_valid(rv4), .redirect_pc(rpc4), .fault(fault4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances one clock and settles just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ready8 = 1'b1; rv8 = 1'b0; rpc8 = '0;
    ready4 = 1'b1; rv4 = 1'b0; rpc4 = '0;
    step(); step();

    // Reset values.
    check("rst_rom_addr", rom_addr8, 8'h00);
    check("rst_valid",    valid8,    1'b0);
    check("rst_data",     data8,     32'h0);
    check("rst_pc",       pc8,       8'h00);
    check("rst_fault",    fault8,    1'b0);
    check("rst_rom_addr4", rom_addr4, 4'd13);

    // Stream from reset with ready high. u4 wraps 13,14,0,1.
    rst = 1'b0;
    step();
    check("s1_valid", valid8, 1'b1);
    check("s1_pc",    pc8,    8'h00);
    check("s1_data",  data8,  32'hA000_0000);
    check("s1_rom_addr", rom_addr8, 8'h01);
    check("w1_pc",    pc4,    4'd13);
    check("w1_data",  data4,  32'hB000_000D);
    check("w1_rom_addr", rom_addr4, 4'd14);
    step();
    check("s2_pc",    pc8,    8'h01);
    check("s2_data",  data8,  32'hA000_0001);
    check("w2_pc",    pc4,    4'd14);
    check("w2_rom_addr", rom_addr4, 4'd0);
    step();
    check("s3_pc",    pc8,    8'h02);
    check("s3_data",  data8,  32'hA000_0002);
    check("w3_pc",    pc4,    4'd0);
    check("w3_data",  data4,  32'hB000_0000);
    step();
    check("s4_valid", valid8, 1'b1);
    check("s4_pc",    pc8,    8'h03);
    check("s4_data",  data8,  32'hA000_0003);
    check("w4_pc",    pc4,    4'd1);
    check("w4_fault", fault4, 1'b0);

    // Backpressure from reset: two entries fill, then the PC stalls at 2.
    rst = 1'b1;
    step();
    rst = 1'b0; ready8 = 1'b0;
    step();
    check("bp1_pc",   pc8,    8'h00);
    check("bp1_rom_addr", rom_addr8, 8'h01);
    step(); step(); step(); step();
    check("bp5_valid", valid8, 1'b1);
    check("bp5_pc",    pc8,    8'h00);
    check("bp5_data",  data8,  32'hA000_0000);
    check("bp5_rom_addr", rom_addr8, 8'h02);
    ready8 = 1'b1;
    step();
    check("bp6_pc",   pc8,    8'h01);
    check("bp6_data", data8,  32'hA000_0001);
    step();
    check("bp7_pc",   pc8,    8'h02);
    step();
    check("bp8_pc",   pc8,    8'h03);
    check("bp8_data", data8,  32'hA000_0003);

    // Redirect while full with a pop in the same cycle.
    rst = 1'b1;
    step();
    rst = 1'b0; ready8 = 1'b0;
    step(); step(); step();
    check("rd_full_rom_addr", rom_addr8, 8'h02);
    ready8 = 1'b1; rv8 = 1'b1; rpc8 = 8'h40;
    #1;
    check("rd_popped_pc", pc8, 8'h00);
    step();
    rv8 = 1'b0;
    check("rd_n1_valid",    valid8,    1'b0);
    check("rd_n1_rom_addr", rom_addr8, 8'h40);
    step();
    check("rd_n2_valid", valid8, 1'b1);
    check("rd_n2_pc",    pc8,    8'h40);
    check("rd_n2_data",  data8,  32'hA000_0040);

    // Redirect to the unbacked address, then recover with a redirect to 3.
    rv8 = 1'b1; rpc8 = 8'hFF;
    step();
    rv8 = 1'b0;
    check("f1_fault",    fault8,    1'b1);
    check("f1_rom_addr", rom_addr8, 8'hFF);
    check("f1_valid",    valid8,    1'b0);
    step();
    check("f2_fault",    fault8,    1'b1);
    check("f2_rom_addr", rom_addr8, 8'hFF);
    check("f2_valid",    valid8,    1'b0);
    rv8 = 1'b1; rpc8 = 8'h03;
    step();
    rv8 = 1'b0;
    check("f3_fault",    fault8,    1'b0);
    check("f3_valid",    valid8,    1'b0);
    check("f3_rom_addr", rom_addr8, 8'h03);
    step();
    check("f4_valid", valid8, 1'b1);
    check("f4_pc",    pc8,    8'h03);
    check("f4_data",  data8,  32'hA000_0003);

    // Reset with a simultaneous redirect: reset wins, including out of FAULT.
    rv8 = 1'b1; rpc8 = 8'hFF;
    step();
    check("r0_fault", fault8, 1'b1);
    rst = 1'b1; rv8 = 1'b1; rpc8 = 8'hFF;
    step();
    rst = 1'b0; rv8 = 1'b0;
    check("r1_fault",    fault8,    1'b0);
    check("r1_rom_addr", rom_addr8, 8'h00);
    check("r1_valid",    valid8,    1'b0);
    check("r1_pc",       pc8,       8'h00);
    step();
    check("r2_valid", valid8, 1'b1);
    check("r2_pc",    pc8,    8'h00);
    check("r2_data",  data8,  32'hA000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
